// File: rtl/orb_pkg.sv
// orb_pkg: widths, state encoding and frame defaults shared by the orbital packer and reader.
package orb_pkg;
    localparam int WORD_W = 12;
    localparam int ADDR_W = 11;
    localparam int FRAME_WORDS_DEF = 2048;

    typedef enum logic [1:0] {IDLE, PRIME, LOAD, RUN} state_t;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a, input int n);
        return (a == ADDR_W'(n - 1)) ? '0 : a + ADDR_W'(1);
    endfunction
endpackage

// File: rtl/orb_frame_reader_if.sv
// orb_frame_reader_if: telemetry RAM read port plus serial output bundle of the frame reader.
interface orb_frame_reader_if;
    import orb_pkg::*;
    logic              en;
    logic [WORD_W-1:0] RdData;
    logic [ADDR_W-1:0] RdAddr;
    logic              RE;
    logic              SW;
    logic              orbBit;
    logic              orbClk;
    logic              frameSync;
    logic              busy;

    modport master (input en, RdData, output RdAddr, RE, SW, orbBit, orbClk, frameSync, busy);
    modport slave  (output en, RdData, input RdAddr, RE, SW, orbBit, orbClk, frameSync, busy);
endinterface

// File: rtl/orb_bit_timer.sv
// orb_bit_timer: divides clk into serial bit periods, giving the bit clock and an end-of-bit strobe.
module orb_bit_timer #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end,
    output logic orb_clk
);
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk)
        if (rst || !run) div_cnt <= '0;
        else div_cnt <= bit_end ? '0 : div_cnt + DW'(1);

    assign bit_end = run && div_cnt == DW'(CLK_DIV - 1);
    assign orb_clk = run && div_cnt < DW'(CLK_DIV / 2);
endmodule

// File: rtl/orb_frame_reader.sv
// orb_frame_reader: reads orbital words from the double-buffered telemetry RAM and shifts them out MSB first,
// flipping the buffer select at each frame boundary.
module orb_frame_reader
    import orb_pkg::*;
#(
    parameter int CLK_DIV     = 16,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
    input logic clk,
    input logic rst,
    orb_frame_reader_if.master bus
);
    localparam int BW = $clog2(WORD_W);

    state_t            state, state_n;
    logic [WORD_W-1:0] shreg, shreg_n, hold;
    logic [BW-1:0]     bit_cnt;
    logic [ADDR_W-1:0] word_cnt, wc_n;
    logic              re_d, bit_end, orb_clk, word_end, last_word;
    logic              prime, ld_first, ld_next, ld;

    orb_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state == RUN),
        .bit_end (bit_end),
        .orb_clk (orb_clk)
    );

    assign bus.orbClk = orb_clk;
    assign bus.busy   = state != IDLE;
    assign word_end   = bit_end && bit_cnt == '0;
    assign last_word  = word_cnt == ADDR_W'(FRAME_WORDS - 1);

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    // en only matters at the frame boundary, so a run request drop never truncates a frame
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.en ? PRIME : IDLE;
            PRIME:   state_n = LOAD;
            LOAD:    state_n = RUN;
            default: state_n = (word_end && last_word && !bus.en) ? IDLE : RUN;
        endcase
    end

    always_comb begin
        prime    = state == IDLE && bus.en;
        ld_first = state == LOAD;
        ld_next  = state == RUN && word_end && state_n == RUN;
        ld       = ld_first || ld_next;
        wc_n     = ld_first ? '0 : wrap_inc(word_cnt, FRAME_WORDS);
        shreg_n  = ld_first ? bus.RdData :
                   ld_next ? hold :
                   (state == RUN && bit_end) ? {shreg[WORD_W-2:0], 1'b0} : shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg         <= '0;
            hold          <= '0;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            re_d          <= 1'b0;
            bus.RE        <= 1'b0;
            bus.RdAddr    <= '0;
            bus.SW        <= 1'b0;
            bus.orbBit    <= 1'b0;
            bus.frameSync <= 1'b0;
        end else begin
            shreg  <= shreg_n;
            re_d   <= bus.RE;
            if (re_d) hold <= bus.RdData;
            // each word load triggers the prefetch of its successor, wrapping to address 0 under the new SW
            bus.RE <= prime || ld;
            if (prime) bus.RdAddr <= '0;
            else if (ld) bus.RdAddr <= wrap_inc(wc_n, FRAME_WORDS);
            if (ld) begin
                bit_cnt  <= BW'(WORD_W - 1);
                word_cnt <= wc_n;
            end else if (state_n == IDLE) begin
                bit_cnt  <= '0;
                word_cnt <= '0;
            end else if (state == RUN && bit_end) begin
                bit_cnt  <= bit_cnt - BW'(1);
            end
            if (ld && wc_n == ADDR_W'(FRAME_WORDS - 1)) bus.SW <= ~bus.SW;
            bus.frameSync <= ld && wc_n == '0;
            bus.orbBit    <= state_n == RUN && shreg_n[WORD_W-1];
        end
    end
endmodule

// File: tb/tb_orb_frame_reader.sv
// tb_orb_frame_reader: timing vector table plus a word scoreboard against a one-cycle-latency double-buffered RAM.
module tb_orb_frame_reader;
    import orb_pkg::*;

    localparam int CD = 4;
    localparam int FW = 4;

    typedef struct {
        int   cyc;
        logic re;
        int   addr;
        logic fs, sw, busy, oc, ob;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    orb_frame_reader_if bus ();

    orb_frame_reader #(.CLK_DIV(CD), .FRAME_WORDS(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WORD_W-1:0] mem [2][FW];
    always @(posedge clk) if (bus.RE) bus.RdData <= mem[bus.SW][bus.RdAddr[1:0]];

    vec_t              tab [15];
    logic [WORD_W-1:0] exp_q [$];
    logic [WORD_W-1:0] acc;
    logic              oc_prev;
    int checks = 0, failures = 0, cyc = 0;
    int re_win, re_sw0, re_late, oc_win, busy_gap, ra_idx, nb;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int pk(input logic re, input int addr, input logic fs, sw, busy, oc, ob);
        return int'({re, addr[1:0], fs, sw, busy, oc, ob});
    endfunction

    function automatic vec_t mk(input int c, input logic re, input int a, input logic fs, sw, busy, oc, ob);
        vec_t v;
        v.cyc = c; v.re = re; v.addr = a; v.fs = fs; v.sw = sw; v.busy = busy; v.oc = oc; v.ob = ob;
        return v;
    endfunction

    task automatic mon();
        if (bus.RE) begin
            if (cyc >= 3 && cyc < 579) re_win++;
            if (!bus.SW) re_sw0++;
            if (cyc >= 148) re_late++;
            chk("rdaddr_seq", int'(bus.RdAddr), ra_idx % FW);
            ra_idx++;
        end
        if (bus.orbClk && cyc >= 3 && cyc < 579) oc_win++;
        if (!bus.busy && cyc >= 1 && cyc < 771) busy_gap++;
        if (bus.frameSync) chk("fsync_period", (cyc - 3) % 192, 0);
        if (!bus.busy) begin
            nb = 0;
            oc_prev = 1'b0;
        end else begin
            if (bus.orbClk && !oc_prev) begin
                acc = {acc[WORD_W-2:0], bus.orbBit};
                nb++;
                if (nb == WORD_W) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow at cycle %0d: got word 0x%0h with none expected", cyc, acc);
                    end else chk("sb_word", int'(acc), int'(exp_q.pop_front()));
                end
            end
            oc_prev = bus.orbClk;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int nf, input int b0);
        for (int f = 0; f < nf; f++)
            for (int w = 0; w < FW; w++) exp_q.push_back(mem[(b0 + f) % 2][w]);
    endtask

    task automatic start();
        rst = 1'b1;
        bus.en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        exp_q.delete();
        nb = 0; oc_prev = 1'b0; re_win = 0; re_sw0 = 0; re_late = 0;
        oc_win = 0; busy_gap = 0; ra_idx = 0;
        bus.en = 1'b1;
        cyc = 0;
    endtask

    initial begin
        mem[0][0] = 12'hA5C; mem[0][1] = 12'h123; mem[0][2] = 12'hFFF; mem[0][3] = 12'h000;
        mem[1][0] = 12'h5A3; mem[1][1] = 12'hC0F; mem[1][2] = 12'h0F0; mem[1][3] = 12'h801;
        tab[0]  = mk(0,   0, 0, 0, 0, 0, 0, 0);
        tab[1]  = mk(1,   1, 0, 0, 0, 1, 0, 0);
        tab[2]  = mk(2,   0, 0, 0, 0, 1, 0, 0);
        tab[3]  = mk(3,   1, 1, 1, 0, 1, 1, 1);
        tab[4]  = mk(4,   0, 0, 0, 0, 1, 1, 1);
        tab[5]  = mk(5,   0, 0, 0, 0, 1, 0, 1);
        tab[6]  = mk(7,   0, 0, 0, 0, 1, 1, 0);
        tab[7]  = mk(51,  1, 2, 0, 0, 1, 1, 0);
        tab[8]  = mk(99,  1, 3, 0, 0, 1, 1, 1);
        tab[9]  = mk(146, 0, 0, 0, 0, 1, 0, 1);
        tab[10] = mk(147, 1, 0, 0, 1, 1, 1, 0);
        tab[11] = mk(194, 0, 0, 0, 1, 1, 0, 0);
        tab[12] = mk(195, 1, 1, 1, 1, 1, 1, 0);
        tab[13] = mk(339, 1, 0, 0, 0, 1, 1, 1);
        tab[14] = mk(387, 1, 1, 1, 0, 1, 1, 1);
        bus.en = 1'b0;

        // continuous run over four frames, en dropped during the fourth
        start();
        push(4, 0);
        for (int i = 0; i < 15; i++) begin
            run_to(tab[i].cyc);
            chk($sformatf("vec%0d", i),
                pk(bus.RE, bus.RE ? int'(bus.RdAddr) : 0, bus.frameSync, bus.SW, bus.busy, bus.orbClk, bus.orbBit),
                pk(tab[i].re, tab[i].addr, tab[i].fs, tab[i].sw, tab[i].busy, tab[i].oc, tab[i].ob));
        end
        run_to(580);
        bus.en = 1'b0;
        run_to(770);
        chk("busy_last_bit", bus.busy, 1);
        step();
        chk("busy_after_frame", bus.busy, 0);
        run_to(780);
        chk("re_3_frames", re_win, 12);
        chk("orbclk_duty", oc_win, 288);
        chk("busy_gaps", busy_gap, 0);
        chk("sb_drained_run", exp_q.size(), 0);

        // en dropped mid first frame
        start();
        push(1, 0);
        run_to(60);
        bus.en = 1'b0;
        run_to(194);
        chk("drop_busy_last", bus.busy, 1);
        step();
        chk("drop_busy_idle", bus.busy, 0);
        chk("drop_sw_kept", bus.SW, 1);
        chk("drop_idle_out", int'({bus.orbBit, bus.orbClk, bus.frameSync}), 0);
        run_to(200);
        chk("drop_re_frame", re_sw0, 4);
        chk("drop_no_prefetch", re_late, 0);
        chk("sb_drained_drop", exp_q.size(), 0);

        // reset during bit 5 of word 2 in the second frame
        start();
        push(2, 0);
        run_to(312);
        chk("sw_before_rst", bus.SW, 1);
        rst = 1'b1;
        step();
        chk("rst_outputs",
            int'({bus.RdAddr, bus.RE, bus.SW, bus.orbBit, bus.orbClk, bus.frameSync, bus.busy}), 0);
        chk("rst_words_pending", exp_q.size(), 2);
        exp_q.delete();
        rst = 1'b0;
        bus.en = 1'b1;
        cyc = 0;
        ra_idx = 0;
        push(1, 0);
        step();
        chk("restart_re_addr_sw", int'({bus.RE, bus.RdAddr, bus.SW}), int'({1'b1, 11'd0, 1'b0}));
        run_to(10);
        bus.en = 1'b0;
        run_to(200);
        chk("restart_idle", bus.busy, 0);
        chk("sb_drained_restart", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/orb_frame_reader.md
# orb_frame_reader

Readout stage downstream of the orbital packer: reads 12-bit orbital words from the shared telemetry RAM, serializes them MSB-first at a fixed bit rate, and produces the frame-sync and buffer-select (SW) signals. The packer writes one half of a double-buffered RAM while this block reads the other half. SW toggles once per frame, which resynchronizes the packer's counters.

## Interface
- CLK_DIV, 16: clk cycles per serial bit; even, ≥4
- FRAME_WORDS, 2048: words per frame; ≤2^ADDR_W
- WORD_W, 12: orbital word width
- ADDR_W, 11: RAM read address width
- clk  in  1  system clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- en  in  1  run request; level
- RdData  in  WORD_W  RAM read data; valid the cycle after RE
- RdAddr  out  ADDR_W  RAM read address within the current buffer
- RE  out  1  RAM read enable; one-cycle pulse
- SW  out  1  buffer select; toggles at the frame boundary
- orbBit  out  1  serial data, MSB first
- orbClk  out  1  bit clock; high for the first CLK_DIV/2 cycles of each bit
- frameSync  out  1  one-cycle pulse on the first cycle of bit 11 of word 0
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: outputs idle.
  - PRIME: RE=1, RdAddr=0.
  - LOAD: capture RdData into the shift register.
  - RUN: serialize.
- Datapath registers: shift register shreg[WORD_W-1:0], hold register, divCnt (0..CLK_DIV-1), bitCnt (WORD_W-1..0), wordCnt (0..FRAME_WORDS-1).
- IDLE→PRIME when en=1.
- PRIME→LOAD unconditionally.
- LOAD→RUN:
  - shreg←RdData; bitCnt=11; divCnt=0; frameSync=1.
  - Next cycle: prefetch RE=1, RdAddr=wordCnt+1.
  - Hold register captures RdData on the following cycle.
- RUN, per clk:
  - divCnt++.
  - At divCnt=CLK_DIV-1, divCnt returns to 0 and the bit ends:
    - bitCnt>0: shift left, bitCnt--.
    - bitCnt=0: shreg←hold, bitCnt=11, wordCnt++ (wraps to 0 after FRAME_WORDS-1), then a prefetch of the next address one cycle later.
- orbBit=shreg[WORD_W-1], registered. orbClk=(divCnt<CLK_DIV/2).
- Frame boundary:
  - When word FRAME_WORDS-1 is loaded into shreg, SW toggles in that same cycle.
  - The following prefetch reads RdAddr=0 under the new SW.
  - frameSync pulses when word 0 of the new frame is loaded.
- en deassertion:
  - Sampled at the frame boundary only; the current frame always completes.
  - If en=0 when the last bit of word FRAME_WORDS-1 ends, go to IDLE.
  - No prefetch is issued. SW keeps its toggled value.
  - en=1 at that point: continue seamlessly with no gap cycle.
- RdAddr arithmetic is modulo 2^ADDR_W. FRAME_WORDS<2^ADDR_W wraps at FRAME_WORDS, not at the power of two.

## Timing
- Reset values: RdAddr=0, RE=0, SW=0, orbBit=0, orbClk=0, frameSync=0, busy=0, state IDLE, all counters 0.
- rst mid-frame: all of the above within one cycle; the partial word is discarded.
- Startup latency: en sampled high at cycle 0 → RE at cycle 1 → first bit valid on orbBit at cycle 3, frameSync high at cycle 3.
- Bit period is exactly CLK_DIV cycles. Word period is WORD_W·CLK_DIV cycles, with no gaps between words or frames.
- Prefetch data lands ≥CLK_DIV-2 cycles before it is needed (CLK_DIV≥4).
- RE is high for exactly one cycle per word; there are FRAME_WORDS reads per frame.
- busy is high from PRIME until IDLE is re-entered.

## Structure
- Shared package orb_pkg holds:
  - WORD_W=12, ADDR_W=11.
  - The state enum {IDLE, PRIME, LOAD, RUN}.
  - The default FRAME_WORDS.
- The packer also references WORD_W and ADDR_W from orb_pkg.
- One sub-module, orb_bit_timer: divCnt, orbClk generation, and a bitEnd strobe.
- FSM, prefetch, and shift logic live in orb_frame_reader.

## Test plan
Bench parameters: CLK_DIV=4, FRAME_WORDS=4. RAM model with one-cycle latency; buffer contents are selected by SW.

- Reset then en=1; RAM words 0xA5C, 0x123, 0xFFF, 0x000 → RE at cycle 1, frameSync at cycle 3, orbBit sequence 1010_0101_1100, 0001_0010_0011, all ones, then all zeros, 4 cycles per bit.
- Two frames with en held → SW toggles in the cycle word 3 loads, frameSync every 192 cycles, no idle cycles, second frame reads the other buffer's contents.
- en dropped mid-frame 1 → remaining words still shifted out, IDLE after the last bit, busy=0, exactly 4 RE pulses in the frame.
- rst asserted during bit 5 of word 2 → next cycle: all outputs at reset values, SW=0, restart on en → RdAddr=0.
- RE accounting over 3 frames → 12 RE pulses, RdAddr sequence 0,1,2,3 repeating, orbClk duty 2/4.
